pattern_scan_ctrl: RTL and testbench

//   Sequences a serial pattern-detect datapath over a stream of parallel words.

---
 rtl/pattern_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts parallel words over valid/ready, serialises each
// MSB-first into an overlapping PAT_W-bit pattern matcher, counts matches per
// scan (saturating) and pulses done when the word marked last has been shifted.
module pattern_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  // Only the most recent PAT_W-1 bits are kept; the bit being consumed
  // completes the PAT_W-bit window.
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                last_q, last_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                cur_bit;
  logic [PAT_W-1:0]    window;
  logic                hist_full;

  assign cur_bit     = shreg_q[DATA_W-1];
  assign window      = {hist_q, cur_bit};
  assign hist_full   = (fill_q >= FILL_W'(PAT_W - 1));
  assign match_count = count_q;

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      pat_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      pat_q     <= pat_d;
      count_q   <= count_d;
    end
  end

  // Next-state, datapath updates and Mealy outputs.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    pat_d       = pat_q;
    count_d     = count_q;
    data_ready  = 1'b0;
    match_pulse = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          count_d = '0;
          hist_d  = '0;
          fill_d  = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (data_valid) begin
          shreg_d   = data_in;
          last_d    = data_last;
          bit_cnt_d = BIT_W'(DATA_W - 1);
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy        = 1'b1;
        match_pulse = (window == pat_q) && hist_full;
        shreg_d     = shreg_q << 1;
        hist_d      = window[PAT_W-2:0];
        if (fill_q != FILL_W'(PAT_W)) begin
          fill_d = fill_q + FILL_W'(1);
        end
        if (match_pulse && (count_q != {CNT_W{1'b1}})) begin
          count_d = count_q + CNT_W'(1);
        end
        if (bit_cnt_q == '0) begin
          state_d = last_q ? S_DONE : S_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: the driver issues scans and pushes the expected
// match positions and final counts (computed by sliding a window over the
// scan's bit stream) into queues; a monitor pops and compares whenever the
// DUT pulses match_pulse or done.
module tb_pattern_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [PAT_W-1:0]  pattern = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_last = 1'b0;
  logic              data_ready;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              busy;
  logic              done;

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .pattern     (pattern),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_last   (data_last),
    .data_ready  (data_ready),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: pulse entries encode (scan_id << 16) | bit index.
  int exp_pulse_q[$];
  int exp_count_q[$];
  int scan_id = 0;

  logic [DATA_W-1:0] words [0:63];
  bit                stream_bits [0:1023];

  // Reference model: slide a PAT_W window over the whole scan bit stream.
  task automatic push_expect(input logic [PAT_W-1:0] pat, input int nwords);
    int nbits;
    int n;
    int w;
    nbits = nwords * DATA_W;
    for (int i = 0; i < nwords; i++)
      for (int b = 0; b < DATA_W; b++)
        stream_bits[i*DATA_W + b] = words[i][DATA_W-1-b];
    n = 0;
    for (int i = PAT_W - 1; i < nbits; i++) begin
      w = 0;
      for (int k = 0; k < PAT_W; k++)
        w = (w << 1) | int'(stream_bits[i-PAT_W+1+k]);
      if (w == int'(pat)) begin
        exp_pulse_q.push_back((scan_id << 16) | i);
        n++;
      end
    end
    exp_count_q.push_back((n > CNT_MAX) ? CNT_MAX : n);
    scan_id++;
  endtask

  // Monitor state.
  int  cyc = 0;
  int  mon_scan = 0;
  int  bit_idx = 0;
  int  last_acc = 0;
  bit  in_scan = 1'b0;
  int  exp_enc;

  // Monitor: compares pulses and done against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      check("rst_ready", int'(data_ready), 0);
      check("rst_pulse", int'(match_pulse), 0);
      check("rst_count", int'(match_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      if (in_scan) begin
        while (exp_pulse_q.size() > 0 && (exp_pulse_q[0] >> 16) == mon_scan)
          void'(exp_pulse_q.pop_front());
        if (exp_count_q.size() > 0) void'(exp_count_q.pop_front());
        mon_scan++;
        in_scan = 1'b0;
      end
      bit_idx = 0;
    end else begin
      if (busy) in_scan = 1'b1;
      if (data_valid && data_ready && data_last) last_acc = cyc;
      if (busy && !data_ready) begin
        if (match_pulse) begin
          exp_enc = (exp_pulse_q.size() > 0) ? exp_pulse_q.pop_front() : -1;
          check("pulse_pos", (mon_scan << 16) | bit_idx, exp_enc);
        end
        bit_idx++;
      end else if (match_pulse) begin
        check("pulse_outside_shift", 1, 0);
      end
      if (done) begin
        while (exp_pulse_q.size() > 0 && (exp_pulse_q[0] >> 16) == mon_scan)
          check("missed_pulse", -1, exp_pulse_q.pop_front() & 16'hFFFF);
        if (exp_count_q.size() > 0)
          check("final_count", int'(match_count), exp_count_q.pop_front());
        else
          check("unexpected_done", 1, 0);
        check("done_latency", cyc - last_acc, DATA_W + 1);
        check("done_busy", int'(busy), 0);
        mon_scan++;
        in_scan = 1'b0;
        bit_idx = 0;
      end
    end
  end

  // Wait (bounded) until the DUT offers data_ready; leaves us at a negedge.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic run_scan(input logic [PAT_W-1:0] pat, input int nwords,
                          input int first_gap, input bit inject_start);
    int gap;
    int cnt0;
    int n;
    push_expect(pat, nwords);
    @(posedge clk); #1;
    start = 1'b1;
    pattern = pat;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = PAT_W'($urandom);
    for (int w = 0; w < nwords; w++) begin
      wait_ready();
      gap = (w == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, 2));
      cnt0 = int'(match_count);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("bp_ready", int'(data_ready), 1);
        check("bp_busy", int'(busy), 1);
        check("bp_count", int'(match_count), cnt0);
      end
      data_in = words[w];
      data_last = (w == nwords - 1);
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      data_last = 1'b0;
      data_in = DATA_W'($urandom);
      if (inject_start && w == 0) begin
        start = 1'b1;
        pattern = ~pat;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    n = 0;
    @(negedge clk);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PAT_W-1:0] pat;
    int nw;

    // Reset state (monitor checks outputs while n_rst is low).
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(data_ready), 0);
    check("idle_busy", int'(busy), 0);

    // Single word, with 5 cycles of LOAD backpressure first.
    words[0] = 8'b1101_1010;
    run_scan(4'b1101, 1, 5, 1'b0);

    // Match straddling a word boundary.
    words[0] = 8'h06;
    words[1] = 8'h80;
    run_scan(4'b1101, 2, 0, 1'b0);

    // Counter saturation.
    for (int i = 0; i < 64; i++) words[i] = 8'h00;
    run_scan(4'b0000, 64, 0, 1'b0);
    @(negedge clk);
    check("sat_hold_after_done", int'(match_count), CNT_MAX);

    // Start pulsed during SHIFT with another pattern is ignored.
    words[0] = 8'b1101_1011;
    words[1] = 8'b0110_1101;
    run_scan(4'b1101, 2, 0, 1'b1);

    // Randomised scans.
    for (int s = 0; s < 25; s++) begin
      pat = PAT_W'($urandom);
      nw = int'($urandom_range(1, 6));
      for (int i = 0; i < nw; i++)
        words[i] = $urandom_range(0, 1) ? DATA_W'($urandom) : {pat, pat};
      run_scan(pat, nw, -1, (s % 4) == 1);
    end

    // Reset in the middle of a SHIFT (word 2, bit index 3).
    words[0] = 8'hFF;
    words[1] = 8'hFF;
    push_expect(4'b1111, 2);
    @(posedge clk); #1;
    start = 1'b1;
    pattern = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_ready();
      data_in = words[w];
      data_last = (w == 1);
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      data_last = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("async_rst_count", int'(match_count), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pulse", int'(match_pulse), 0);
    check("async_rst_ready", int'(data_ready), 0);
    check("async_rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_ready", int'(data_ready), 0);
      check("post_rst_count", int'(match_count), 0);
    end

    // A normal scan still works after the abort.
    words[0] = 8'b1101_1010;
    run_scan(4'b1101, 1, 0, 1'b0);

    repeat (4) @(negedge clk);
    check("pulse_queue_drained", exp_pulse_q.size(), 0);
    check("count_queue_drained", exp_count_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
